alu_arbiter: RTL

//  Shares the single-cycle 32-bit ALU between two requesters, e.g. the execute stage (r0) and the

---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu_arb_rsp_slot.sv | 56 +++++
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
//   Shared definitions for the two-requester ALU arbiter:
//   - ALU op code constants understood by the shared ALU
//   - lock-state enum used when ALU_ARB_LOCK_EN is defined
//   - default width of the opaque request tag
package alu_arb_pkg;

  localparam int DEFAULT_TAG_W = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;

  // Grant-lock states: IDLE arbitrates round-robin, LOCKn pins the ALU to requester n.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_e;

endpackage

// File: rtl/alu_arb_rsp_slot.sv
// alu_arb_rsp_slot
//   One-entry response register for a single requester. Captures the ALU
//   result, zero flag and request tag when its request is accepted and holds
//   them until the consumer drains the slot. Also reports whether the
//   requester may be granted this cycle (slot empty or being drained).
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   req_valid           requester has a request pending
//   load                request accepted this cycle, capture at next edge
//   rsp_ready           consumer takes the response this cycle
//   load_result/zero/tag  values captured on load
//   eligible            request may be granted this cycle
//   rsp_valid/result/zero/tag  registered response
module alu_arb_rsp_slot
  import alu_arb_pkg::*;
#(
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             load,
  input  logic             rsp_ready,
  input  logic [31:0]      load_result,
  input  logic             load_zero,
  input  logic [TAG_W-1:0] load_tag,
  output logic             eligible,
  output logic             rsp_valid,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag
);

  // A full slot can accept a new result only in the cycle it is being drained,
  // which lets a requester keep one op per cycle while its consumer keeps up.
  assign eligible = req_valid & (~rsp_valid | rsp_ready);

  // Load takes precedence over drain so a drain-and-refill leaves the slot full
  // with the new result; a stalled slot simply holds its contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
    end else if (load) begin
      rsp_valid  <= 1'b1;
      rsp_result <= load_result;
      rsp_zero   <= load_zero;
      rsp_tag    <= load_tag;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one single-cycle 32-bit ALU between two requesters (r0, r1) with
//   round-robin arbitration. The granted request drives the ALU inputs
//   combinationally; the ALU result is registered into that requester's
//   response slot one cycle later.
// Configuration
//   ALU_ARB_LOCK_EN  when defined, adds r0_lock/r1_lock and a lock FSM that
//                    keeps the grant on one requester across back-to-back ops.
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   rN_valid/ready                   request handshake (N = 0, 1)
//   rN_a, rN_b, rN_alucont, rN_sltunsigned, rN_tag   request fields
//   rN_lock                          grant lock request (ALU_ARB_LOCK_EN only)
//   rN_rsp_valid/ready               response handshake
//   rN_rsp_result/zero/tag           registered response
//   alu_a, alu_b, alu_alucont, alu_sltunsigned       to the shared ALU
//   alu_result, alu_zero             from the shared ALU (combinational)
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int TAG_W   = DEFAULT_TAG_W,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_a,
  input  logic [31:0]      r0_b,
  input  logic [3:0]       r0_alucont,
  input  logic             r0_sltunsigned,
  input  logic [TAG_W-1:0] r0_tag,
`ifdef ALU_ARB_LOCK_EN
  input  logic             r0_lock,
  input  logic             r1_lock,
`endif
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [31:0]      r0_rsp_result,
  output logic             r0_rsp_zero,
  output logic [TAG_W-1:0] r0_rsp_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_a,
  input  logic [31:0]      r1_b,
  input  logic [3:0]       r1_alucont,
  input  logic             r1_sltunsigned,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [31:0]      r1_rsp_result,
  output logic             r1_rsp_zero,
  output logic [TAG_W-1:0] r1_rsp_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_alucont,
  output logic             alu_sltunsigned,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero
);

  logic elig0, elig1;
  logic grant0, grant1;
  logic hold0, hold1;
  // prio = 0: r0 wins a tie, prio = 1: r1 wins a tie
  logic prio, prio_next;

  alu_arb_rsp_slot #(.TAG_W(TAG_W)) u_slot0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (r0_valid),
    .load        (grant0),
    .rsp_ready   (r0_rsp_ready),
    .load_result (alu_result),
    .load_zero   (alu_zero),
    .load_tag    (r0_tag),
    .eligible    (elig0),
    .rsp_valid   (r0_rsp_valid),
    .rsp_result  (r0_rsp_result),
    .rsp_zero    (r0_rsp_zero),
    .rsp_tag     (r0_rsp_tag)
  );

  alu_arb_rsp_slot #(.TAG_W(TAG_W)) u_slot1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (r1_valid),
    .load        (grant1),
    .rsp_ready   (r1_rsp_ready),
    .load_result (alu_result),
    .load_zero   (alu_zero),
    .load_tag    (r1_tag),
    .eligible    (elig1),
    .rsp_valid   (r1_rsp_valid),
    .rsp_result  (r1_rsp_result),
    .rsp_zero    (r1_rsp_zero),
    .rsp_tag     (r1_rsp_tag)
  );

`ifdef ALU_ARB_LOCK_EN
  lock_state_e lock_state, lock_next;

  // Lock state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lock_state <= IDLE;
    else          lock_state <= lock_next;
  end

  // A lock is taken by being granted with lock set, and released by the holder
  // dropping lock, whether or not it is presenting a request that cycle.
  always_comb begin
    lock_next = lock_state;
    case (lock_state)
      IDLE: begin
        if (grant0 && r0_lock)      lock_next = LOCK0;
        else if (grant1 && r1_lock) lock_next = LOCK1;
      end
      LOCK0:   if (!r0_lock) lock_next = IDLE;
      LOCK1:   if (!r1_lock) lock_next = IDLE;
      default: lock_next = IDLE;
    endcase
  end

  assign hold0 = (lock_state == LOCK0);
  assign hold1 = (lock_state == LOCK1);
`else
  assign hold0 = 1'b0;
  assign hold1 = 1'b0;
`endif

  // Grant selection: a lock holder is the only candidate; otherwise a lone
  // eligible requester wins and a tie goes to the priority holder. An
  // ineligible (stalled) requester never wins, so it cannot burn priority.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (hold0) begin
      grant0 = elig0;
    end else if (hold1) begin
      grant1 = elig1;
    end else begin
      grant0 = elig0 & (~elig1 | ~prio);
      grant1 = elig1 & (~elig0 |  prio);
    end
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // Priority passes to the other requester after every grant, and stays
  // frozen while a lock is held.
  always_comb begin
    prio_next = prio;
    if (!hold0 && !hold1) begin
      if (grant0)      prio_next = 1'b1;
      else if (grant1) prio_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prio <= (RR_INIT != 0);
    else          prio <= prio_next;
  end

  // ALU inputs follow the granted request and are forced to zero when idle.
  always_comb begin
    alu_a           = 32'd0;
    alu_b           = 32'd0;
    alu_alucont     = 4'd0;
    alu_sltunsigned = 1'b0;
    if (grant0) begin
      alu_a           = r0_a;
      alu_b           = r0_b;
      alu_alucont     = r0_alucont;
      alu_sltunsigned = r0_sltunsigned;
    end else if (grant1) begin
      alu_a           = r1_a;
      alu_b           = r1_b;
      alu_alucont     = r1_alucont;
      alu_sltunsigned = r1_sltunsigned;
    end
  end

endmodule
